// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the MIPS core. Bypasses same-cycle write-back into
// the decoded operands, detects load-use hazards and inserts bubbles on stall or flush.
module id_ex_stage #(
  parameter int DW = 32,
  parameter int AW = 5,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          id_valid,
  input  logic [AW-1:0] id_rs,
  input  logic [AW-1:0] id_rt,
  input  logic [AW-1:0] id_rd,
  input  logic          id_uses_rt,
  input  logic          id_regdst,
  input  logic          id_regwrite,
  input  logic          id_memread,
  input  logic          id_memwrite,
  input  logic          id_alusrc,
  input  logic [3:0]    id_aluop,
  input  logic [DW-1:0] id_imm,
  input  logic [DW-1:0] rf_data1,
  input  logic [DW-1:0] rf_data2,
  input  logic          wb_we,
  input  logic [AW-1:0] wb_reg,
  input  logic [DW-1:0] wb_data,
  input  logic          flush,
  input  logic          ex_hold,
  output logic          stall,
  output logic          ex_valid,
  output logic          ex_regwrite,
  output logic          ex_memread,
  output logic          ex_memwrite,
  output logic          ex_alusrc,
  output logic [3:0]    ex_aluop,
  output logic [DW-1:0] ex_a,
  output logic [DW-1:0] ex_b,
  output logic [DW-1:0] ex_imm,
  output logic [AW-1:0] ex_rs,
  output logic [AW-1:0] ex_rt,
  output logic [AW-1:0] ex_dest,
  output logic [CW-1:0] stall_count
);

  logic          byp_a, byp_b;
  logic [DW-1:0] op_a, op_b;
  logic          haz;
  logic          count_en;
  logic [AW-1:0] dest_sel;

  // Register 0 is hard-wired, so a write-back to it must never be forwarded.
  assign byp_a = wb_we && (wb_reg == id_rs) && (id_rs != '0);
  assign byp_b = wb_we && (wb_reg == id_rt) && (id_rt != '0);
  assign op_a  = byp_a ? wb_data : rf_data1;
  assign op_b  = byp_b ? wb_data : rf_data2;

  assign haz = id_valid && ex_valid && ex_memread && (ex_dest != '0) &&
               ((ex_dest == id_rs) || (id_uses_rt && (ex_dest == id_rt)));

  assign stall    = (haz && !flush) || ex_hold;
  assign count_en = haz && !flush && !ex_hold;
  assign dest_sel = id_regdst ? id_rd : id_rt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid    <= 1'b0;
      ex_regwrite <= 1'b0;
      ex_memread  <= 1'b0;
      ex_memwrite <= 1'b0;
      ex_alusrc   <= 1'b0;
      ex_aluop    <= '0;
      ex_a        <= '0;
      ex_b        <= '0;
      ex_imm      <= '0;
      ex_rs       <= '0;
      ex_rt       <= '0;
      ex_dest     <= '0;
    end else if ((flush && !ex_hold) || (!ex_hold && haz)) begin
      ex_valid    <= 1'b0;
      ex_regwrite <= 1'b0;
      ex_memread  <= 1'b0;
      ex_memwrite <= 1'b0;
      ex_alusrc   <= 1'b0;
      ex_aluop    <= '0;
      ex_a        <= '0;
      ex_b        <= '0;
      ex_imm      <= '0;
      ex_rs       <= '0;
      ex_rt       <= '0;
      ex_dest     <= '0;
    end else if (!ex_hold) begin
      ex_valid    <= id_valid;
      ex_regwrite <= id_valid && id_regwrite;
      ex_memread  <= id_valid && id_memread;
      ex_memwrite <= id_valid && id_memwrite;
      ex_alusrc   <= id_valid && id_alusrc;
      ex_aluop    <= id_valid ? id_aluop : 4'h0;
      ex_a        <= op_a;
      ex_b        <= op_b;
      ex_imm      <= id_imm;
      ex_rs       <= id_rs;
      ex_rt       <= id_rt;
      ex_dest     <= (id_valid && id_regwrite) ? dest_sel : '0;
    end
  end

  // Counts only real hazard stalls; saturates rather than wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      stall_count <= '0;
    else if (count_en && (stall_count != '1))
      stall_count <= stall_count + {{(CW-1){1'b0}}, 1'b1};
  end

endmodule
